// File: rtl/weight_sram_loader_if.sv
// Load request, weight stream and per-bank write-side SRAM signals of weight_sram_loader.
// base_addr is present only when WEIGHT_LOADER_BASE_ADDR_EN is defined.
interface weight_sram_loader_if #(
    parameter int unsigned NUM_BANKS = 288,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 16
);
    logic              start;
    logic [7:0]        load_rows;
`ifdef WEIGHT_LOADER_BASE_ADDR_EN
    logic [ADDR_W-1:0] base_addr;
`endif
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              weight_SRAM_rw_select;
    logic [ADDR_W-1:0] weight_SRAM_A_write   [0:NUM_BANKS-1];
    logic              weight_SRAM_CEN_write [0:NUM_BANKS-1];
    logic              weight_SRAM_WEN_write [0:NUM_BANKS-1];
    logic [DATA_W-1:0] weight_SRAM_D_write   [0:NUM_BANKS-1];

`ifdef WEIGHT_LOADER_BASE_ADDR_EN
    modport master (
        output start, load_rows, base_addr, in_valid, in_data,
        input  in_ready, busy, done, weight_SRAM_rw_select,
        input  weight_SRAM_A_write, weight_SRAM_CEN_write, weight_SRAM_WEN_write, weight_SRAM_D_write
    );
    modport slave (
        input  start, load_rows, base_addr, in_valid, in_data,
        output in_ready, busy, done, weight_SRAM_rw_select,
        output weight_SRAM_A_write, weight_SRAM_CEN_write, weight_SRAM_WEN_write, weight_SRAM_D_write
    );
`else
    modport master (
        output start, load_rows, in_valid, in_data,
        input  in_ready, busy, done, weight_SRAM_rw_select,
        input  weight_SRAM_A_write, weight_SRAM_CEN_write, weight_SRAM_WEN_write, weight_SRAM_D_write
    );
    modport slave (
        input  start, load_rows, in_valid, in_data,
        output in_ready, busy, done, weight_SRAM_rw_select,
        output weight_SRAM_A_write, weight_SRAM_CEN_write, weight_SRAM_WEN_write, weight_SRAM_D_write
    );
`endif
endinterface

// File: rtl/weight_sram_loader.sv
// Write-side loader: scatters a weight stream round-robin over the SRAM banks, row by row.
// Optional WEIGHT_LOADER_BASE_ADDR_EN adds a start row address (base_addr) sampled with start.
module weight_sram_loader #(
    parameter int unsigned NUM_BANKS = 288,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    weight_sram_loader_if.slave bus
);
    localparam int unsigned BANK_W   = $clog2(NUM_BANKS);
    localparam int unsigned ROWS_W   = 8;
    localparam int unsigned MAX_ROWS = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state, state_next;
    logic [BANK_W-1:0] bank_idx, bank_idx_next;
    logic [ADDR_W-1:0] row_addr, row_addr_next, row_base;
    logic [ROWS_W-1:0] rows_left, rows_left_next, rows_req;
    logic              accept, last_bank;
    logic              in_ready_next, busy_next, done_next, rw_select_next;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_bank = (bank_idx == BANK_W'(NUM_BANKS - 1));
    assign rows_req  = (bus.load_rows > ROWS_W'(MAX_ROWS)) ? ROWS_W'(MAX_ROWS) : bus.load_rows;

`ifdef WEIGHT_LOADER_BASE_ADDR_EN
    assign row_base = bus.base_addr;
`else
    assign row_base = '0;
`endif

    // Next state, counters and next values of the registered status outputs.
    always_comb begin
        state_next     = state;
        bank_idx_next  = bank_idx;
        row_addr_next  = row_addr;
        rows_left_next = rows_left;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    bank_idx_next  = '0;
                    row_addr_next  = row_base;
                    rows_left_next = rows_req;
                    state_next     = (rows_req == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (last_bank) begin
                        bank_idx_next  = '0;
                        row_addr_next  = row_addr + ADDR_W'(1);
                        rows_left_next = rows_left - ROWS_W'(1);
                        if (rows_left == ROWS_W'(1)) state_next = S_DONE;
                    end else begin
                        bank_idx_next = bank_idx + BANK_W'(1);
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // rw_select also covers the cycle in which the last strobe is still on the banks.
        in_ready_next  = (state_next == S_LOAD);
        rw_select_next = (state == S_LOAD) || (state_next == S_LOAD);
        done_next      = (state == S_DONE);
        busy_next      = (state != S_IDLE) || (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= S_IDLE;
            bank_idx                  <= '0;
            row_addr                  <= '0;
            rows_left                 <= '0;
            bus.in_ready              <= 1'b0;
            bus.busy                  <= 1'b0;
            bus.done                  <= 1'b0;
            bus.weight_SRAM_rw_select <= 1'b0;
        end else begin
            state                     <= state_next;
            bank_idx                  <= bank_idx_next;
            row_addr                  <= row_addr_next;
            rows_left                 <= rows_left_next;
            bus.in_ready              <= in_ready_next;
            bus.busy                  <= busy_next;
            bus.done                  <= done_next;
            bus.weight_SRAM_rw_select <= rw_select_next;
        end
    end

    // Per-bank strobes last one cycle; address and data hold until the bank is written again.
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic hit;
        assign hit = accept && (bank_idx == BANK_W'(g));

        always_ff @(posedge clk) begin
            if (rst) begin
                bus.weight_SRAM_CEN_write[g] <= 1'b1;
                bus.weight_SRAM_WEN_write[g] <= 1'b1;
                bus.weight_SRAM_A_write[g]   <= '0;
                bus.weight_SRAM_D_write[g]   <= '0;
            end else begin
                bus.weight_SRAM_CEN_write[g] <= !hit;
                bus.weight_SRAM_WEN_write[g] <= !hit;
                if (hit) begin
                    bus.weight_SRAM_A_write[g] <= row_addr;
                    bus.weight_SRAM_D_write[g] <= bus.in_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_weight_sram_loader.sv
// Randomized bench for weight_sram_loader against a word-count based reference model.
// Build with WEIGHT_LOADER_BASE_ADDR_EN to also exercise the base address option.
module tb_weight_sram_loader;
    localparam int unsigned NUM_BANKS = 288;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned DEPTH     = 128;
    localparam int unsigned NEVER     = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_sram_loader_if #(.NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    weight_sram_loader #(.NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: a load is "total" words; word n goes to bank n%288, row base+n/288.
    typedef enum {P_IDLE, P_LOAD, P_FIN} phase_t;
    phase_t      ph = P_IDLE;
    int unsigned total, n, base;
    bit          exp_strobe, exp_done;
    int unsigned exp_bank, exp_addr, exp_data;
    int unsigned exp_a [NUM_BANKS];
    int unsigned exp_d [NUM_BANKS];
    int unsigned cyc, start_at, done_at, rw_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned eff_base(input int unsigned b);
`ifdef WEIGHT_LOADER_BASE_ADDR_EN
        return b % DEPTH;
`else
        return 0;
`endif
    endfunction

    task automatic model_edge(input bit s, input int unsigned rows, input bit v,
                              input int unsigned data, input int unsigned b, input bit r);
        int unsigned rr;
        exp_done   = (ph == P_FIN);
        exp_strobe = 1'b0;
        if (r) begin
            ph       = P_IDLE;
            exp_done = 1'b0;
            n        = 0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                exp_a[i] = 0;
                exp_d[i] = 0;
            end
        end else begin
            case (ph)
                P_IDLE: if (s) begin
                    rr       = (rows > DEPTH) ? DEPTH : rows;
                    start_at = cyc;
                    n        = 0;
                    total    = rr * NUM_BANKS;
                    base     = b;
                    ph       = (rr == 0) ? P_FIN : P_LOAD;
                end
                P_LOAD: if (v) begin
                    exp_strobe      = 1'b1;
                    exp_bank        = n % NUM_BANKS;
                    exp_addr        = (base + n / NUM_BANKS) % DEPTH;
                    exp_data        = data;
                    exp_a[exp_bank] = exp_addr;
                    exp_d[exp_bank] = data;
                    n++;
                    if (n == total) ph = P_FIN;
                end
                default: ph = P_IDLE;
            endcase
        end
    endtask

    task automatic check_outputs();
        int unsigned lows    = 0;
        int unsigned idx     = 0;
        int unsigned wen_bad = 0;
        int unsigned rb;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bus.weight_SRAM_CEN_write[i] == 1'b0) begin
                lows++;
                idx = i;
            end
            if (bus.weight_SRAM_WEN_write[i] !== bus.weight_SRAM_CEN_write[i]) wen_bad++;
        end
        check("in_ready", bus.in_ready, ph == P_LOAD);
        check("busy", bus.busy, (ph != P_IDLE) || exp_done);
        check("done", bus.done, exp_done);
        check("rw_select", bus.weight_SRAM_rw_select, (ph == P_LOAD) || exp_strobe);
        check("cen_low_count", lows, exp_strobe ? 1 : 0);
        check("wen_eq_cen", wen_bad, 0);
        if (exp_strobe) begin
            check("strobe_bank", idx, exp_bank);
            check("strobe_addr", bus.weight_SRAM_A_write[exp_bank], exp_addr);
            check("strobe_data", bus.weight_SRAM_D_write[exp_bank], exp_data);
        end
        rb = $urandom_range(NUM_BANKS - 1);
        check("hold_addr", bus.weight_SRAM_A_write[rb], exp_a[rb]);
        check("hold_data", bus.weight_SRAM_D_write[rb], exp_d[rb]);
        if (bus.weight_SRAM_rw_select) rw_cnt++;
        if (bus.done) done_at = cyc;
    endtask

    task automatic step(input bit s, input int unsigned rows, input bit v,
                        input int unsigned data, input int unsigned b, input bit r);
        bus.start     = s;
        bus.load_rows = 8'(rows);
        bus.in_valid  = v;
        bus.in_data   = 16'(data);
        rst           = r;
`ifdef WEIGHT_LOADER_BASE_ADDR_EN
        bus.base_addr = 7'(b);
`endif
        @(posedge clk);
        cyc++;
        model_edge(s, rows & 255, v, data & 16'hFFFF, eff_base(b), r);
        @(negedge clk);
        check_outputs();
    endtask

    // gap: 0 = full rate, 1 = random valid, N>1 = valid low every Nth cycle.
    task automatic run_load(input int unsigned rows, input int unsigned b, input int unsigned gap,
                            input int unsigned restart_at, input int unsigned rst_after, input bit seq);
        int unsigned rr = (rows > DEPTH) ? DEPTH : rows;
        int unsigned c  = 0;
        bit          v;
        rw_cnt  = 0;
        done_at = 0;
        step(1'b1, rows, 1'b0, 0, b, 1'b0);
        while (ph != P_IDLE && c < 40000) begin
            case (gap)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(1));
                default: v = (c % gap) != (gap - 1);
            endcase
            step(c == restart_at, $urandom_range(255), v, seq ? n : $urandom_range(16'hFFFF), b,
                 (rst_after != 0) && (n == rst_after));
            c++;
        end
        check("load_end", ph == P_IDLE, 1);
        if (gap == 0 && rst_after == 0) begin
            check("done_latency", done_at - start_at, rr * NUM_BANKS + 1);
            check("rw_select_len", rw_cnt, (rr == 0) ? 0 : rr * NUM_BANKS + 1);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.load_rows = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        rst           = 1'b1;
`ifdef WEIGHT_LOADER_BASE_ADDR_EN
        bus.base_addr = '0;
`endif
        for (int i = 0; i < NUM_BANKS; i++) begin
            exp_a[i] = 0;
            exp_d[i] = 0;
        end
        @(negedge clk);
        step(1'b0, 0, 1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 1'b0, 0, 0, 1'b0);

        run_load(1, 0, 0, NEVER, 0, 1'b1);
        run_load(2, 0, 3, NEVER, 0, 1'b1);
        run_load(0, 0, 0, NEVER, 0, 1'b1);
        step(1'b0, 0, 1'b1, 0, 0, 1'b0);
        run_load(1, $urandom_range(127), 1, 150, 0, 1'b0);
        run_load(3, 0, 0, NEVER, 100, 1'b0);
        run_load(1, 0, 0, NEVER, 0, 1'b1);
`ifdef WEIGHT_LOADER_BASE_ADDR_EN
        run_load(2, 127, 0, NEVER, 0, 1'b1);
`endif
        run_load(200, $urandom_range(127), 0, NEVER, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_load($urandom_range(3), $urandom_range(127), 1, $urandom_range(400), 0, 1'b0);
        end
        step(1'b0, 0, 1'b0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/weight_sram_loader.md
# weight_sram_loader

Write-side controller for the 288-bank weight SRAM array. Accepts a valid/ready stream of weight words, scatters them round-robin across the banks (bank-major within a row, row address incrementing after each full sweep), and drives the write-side address, chip-enable, write-enable, data and rw_select inputs of the weight SRAM read/write mux. Raises rw_select for exactly the span of a load so the mux hands the banks to this block, then returns them to the read path.

## Interface
- NUM_BANKS, 288, number of weight SRAM banks
- ADDR_W, 7, bank address width (depth 128)
- DATA_W, 16, weight word width
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle load request; honoured only in IDLE
- load_rows  input  8  rows to load, 0..128; sampled with start
- in_valid  input  1  weight word valid
- in_data  input  DATA_W  weight word
- in_ready  output  1  loader accepts in_data this cycle
- busy  output  1  high from accepted start until DONE ends
- done  output  1  one-cycle completion pulse
- weight_SRAM_rw_select  output  1  1 = write side owns the banks
- weight_SRAM_A_write  output  ADDR_W x [0:NUM_BANKS-1]  per-bank write address
- weight_SRAM_CEN_write  output  1 x [0:NUM_BANKS-1]  per-bank chip enable, active-low
- weight_SRAM_WEN_write  output  1 x [0:NUM_BANKS-1]  per-bank write enable, active-low
- weight_SRAM_D_write  output  DATA_W x [0:NUM_BANKS-1]  per-bank write data

## Operation
- States: IDLE, LOAD, DONE. Counters: bank_idx (0..287), row_addr (ADDR_W), rows_left (8 bit).
- IDLE: start with load_rows>0 -> LOAD; bank_idx=0, row_addr=base (0, see Configuration), rows_left=load_rows, rw_select=1, busy=1. start with load_rows=0 -> DONE directly, rw_select stays 0, no writes.
- LOAD: in_ready=1. On in_valid&&in_ready: bank bank_idx gets CEN=0, WEN=0, A=row_addr, D=in_data; all other banks CEN=1, WEN=1, A/D hold last value. bank_idx++; at 287 wraps to 0, row_addr++ (mod 128), rows_left--.
- Accepting word 287 with rows_left==1 -> DONE.
- No accept in a cycle (in_valid=0) -> all CEN=1, WEN=1; counters hold.
- DONE: one cycle; done=1, in_ready=0, rw_select=0, all CEN/WEN=1; -> IDLE, busy=0.
- start outside IDLE ignored; load_rows=129..255 clamped to 128.
- Reset values: in_ready=0, busy=0, done=0, rw_select=0, all CEN=1, all WEN=1, all A=0, all D=0; state IDLE, counters 0.
- rst mid-load: next edge forces reset values; words already written stay in SRAM; stream not resumed.

## Timing
- All outputs registered. Word accepted at edge k -> write strobes visible after edge k, SRAM captures at edge k+1.
- At most one bank has CEN=0 in any cycle; strobes last exactly one cycle per accepted word.
- rw_select rises at the start-accepting edge (one cycle before the earliest accept) and falls at the edge after the last accept, same edge CEN returns high.
- Full-rate load of R rows: start edge + R*288 accept cycles + 1 DONE cycle; done asserted R*288+1 cycles after the start edge.
- in_ready is registered state-derived; no combinational path from in_valid to in_ready.

## Configuration
- WEIGHT_LOADER_BASE_ADDR_EN defined: extra input base_addr (ADDR_W), sampled with start; row_addr starts there and wraps 127 -> 0.
- Undefined: no base_addr port; row_addr starts at 0.

## Test plan
- start, load_rows=1, in_data=i on cycle i for 288 consecutive cycles -> bank i written A=0, D=i, one bank per cycle; done 289 cycles after start; rw_select high for exactly 289 cycles.
- load_rows=2 with in_valid deasserted every 3rd cycle -> no strobes in idle cycles; word 288 lands in bank 0 at A=1; word 575 in bank 287 at A=1; done after last accept +1.
- start with load_rows=0 -> done pulse next cycle, rw_select never rises, all CEN stay 1.
- start pulsed again mid-load -> ignored; counters and write sequence unchanged.
- rst asserted after 100 accepted words -> next cycle all CEN/WEN=1, rw_select=0, in_ready=0, busy=0; fresh start restarts at bank 0, A=0.
- With WEIGHT_LOADER_BASE_ADDR_EN, base_addr=127, load_rows=2 -> row 0 writes A=127, row 1 writes A=0.
